// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back path.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 1 << AW;

    typedef logic [AW-1:0] reg_addr_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter; grant doubles as ready, pointer moves only on accept.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_valid_i,
    input  logic m_valid_i,
    output logic a_grant_o,
    output logic m_grant_o
);

    wb_src_e last_q, last_d;

    // On a tie the side that did not win last time takes the port.
    always_comb begin
        a_grant_o = a_valid_i && (!m_valid_i || (last_q == WB_MEM));
        m_grant_o = m_valid_i && (!a_valid_i || (last_q == WB_ALU));
        last_d    = last_q;
        if (a_grant_o) begin
            last_d = WB_ALU;
        end else if (m_grant_o) begin
            last_d = WB_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= WB_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU/load write-backs onto the register-file write port and keeps
// the busy scoreboard used by decode for RAW/WAW stalls.
module regfile_wb_scheduler #(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [AW-1:0]         a_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [AW-1:0]         m_rd,
    input  logic [XLEN-1:0]       m_data,
    output logic [AW-1:0]         rd_address,
    output logic [XLEN-1:0]       rd_data_in,
    output logic                  rd_write_enb,
    input  logic [AW-1:0]         chk1_address,
    input  logic [AW-1:0]         chk2_address,
    output logic                  chk1_busy,
    output logic                  chk2_busy,
    output logic [(1<<AW)-1:0]    busy_mask,
    output logic                  wb_unexpected
);
    import regfile_pkg::*;

    localparam int NREG = 1 << AW;

    logic            a_grant;
    logic            m_grant;
    logic            accept;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            issue_set;

    logic [NREG-1:0] busy_q, busy_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            unexp_q, unexp_d;

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .a_valid_i (a_valid),
        .m_valid_i (m_valid),
        .a_grant_o (a_grant),
        .m_grant_o (m_grant)
    );

    assign a_ready       = a_grant;
    assign m_ready       = m_grant;
    assign rd_address    = addr_q;
    assign rd_data_in    = data_q;
    assign rd_write_enb  = wen_q;
    assign busy_mask     = busy_q;
    assign wb_unexpected = unexp_q;
    assign chk1_busy     = busy_q[chk1_address];
    assign chk2_busy     = busy_q[chk2_address];

    // A write committing this cycle frees its destination for a new issue.
    assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd]
                         || (wen_q && (addr_q == issue_rd));
    assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

    always_comb begin
        accept   = a_grant || m_grant;
        win_rd   = m_grant ? m_rd   : a_rd;
        win_data = m_grant ? m_data : a_data;

        wen_d  = accept && (win_rd != '0);
        addr_d = accept ? win_rd   : addr_q;
        data_d = accept ? win_data : data_q;

        unexp_d = unexp_q || (accept && (win_rd != '0) && !busy_q[win_rd]);

        // Clear first so a same-edge re-issue of the register keeps it busy.
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= '0;
            unexp_q <= 1'b0;
        end else begin
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            unexp_q <= unexp_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a behavioural register file on the write port.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        a_valid, a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        m_valid, m_ready;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [4:0]  rd_address;
    logic [31:0] rd_data_in;
    logic        rd_write_enb;
    logic [4:0]  chk1_address, chk2_address;
    logic        chk1_busy, chk2_busy;
    logic [31:0] busy_mask;
    logic        wb_unexpected;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [0:31] = '{default: 32'h0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_write_enb) rf[rd_address] <= rd_data_in;
    end

    regfile_wb_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_rd         (m_rd),
        .m_data       (m_data),
        .rd_address   (rd_address),
        .rd_data_in   (rd_data_in),
        .rd_write_enb (rd_write_enb),
        .chk1_address (chk1_address),
        .chk2_address (chk2_address),
        .chk1_busy    (chk1_busy),
        .chk2_busy    (chk2_busy),
        .busy_mask    (busy_mask),
        .wb_unexpected(wb_unexpected)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        issue_rd = 5'd5; chk1_address = 5'd0; chk2_address = 5'd5;
        #1;
        checks++; if (rd_write_enb !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b want 0", rd_write_enb); end
        checks++; if (rd_address !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_address); end
        checks++; if (rd_data_in !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rd_data_in); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
        checks++; if (wb_unexpected !== 1'b0) begin errors++; $display("FAIL reset_unexp: got %0b want 0", wb_unexpected); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0b want 1", issue_ready); end
        checks++; if ({a_ready, m_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {a_ready, m_ready}); end
        checks++; if ({chk1_busy, chk2_busy} !== 2'b00) begin errors++; $display("FAIL reset_chk: got %b want 00", {chk1_busy, chk2_busy}); end
    endtask

    task automatic test_single_alu();
        issue_valid = 1'b1; issue_rd = 5'd5; chk1_address = 5'd5;
        step();
        issue_valid = 1'b0;
        checks++; if (busy_mask !== 32'h0000_0020) begin errors++; $display("FAIL alu_busy_set: got %h want 00000020", busy_mask); end
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        checks++; if ({a_ready, m_ready} !== 2'b10) begin errors++; $display("FAIL alu_ready: got %b want 10", {a_ready, m_ready}); end
        step();
        a_valid = 1'b0;
        checks++; if (rd_write_enb !== 1'b1) begin errors++; $display("FAIL alu_wen: got %0b want 1", rd_write_enb); end
        checks++; if (rd_address !== 5'd5) begin errors++; $display("FAIL alu_addr: got %0d want 5", rd_address); end
        checks++; if (rd_data_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_data: got %h want deadbeef", rd_data_in); end
        checks++; if (chk1_busy !== 1'b1) begin errors++; $display("FAIL alu_chk_pending: got %0b want 1", chk1_busy); end
        step();
        checks++; if (chk1_busy !== 1'b0) begin errors++; $display("FAIL alu_chk_clear: got %0b want 0", chk1_busy); end
        checks++; if (rd_write_enb !== 1'b0) begin errors++; $display("FAIL alu_wen_drop: got %0b want 0", rd_write_enb); end
        checks++; if (rd_address !== 5'd5) begin errors++; $display("FAIL alu_addr_hold: got %0d want 5", rd_address); end
        checks++; if (rf[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_rf: got %h want deadbeef", rf[5]); end
    endtask

    task automatic test_contention();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd4;
        step();
        issue_valid = 1'b0;
        checks++; if (busy_mask !== 32'h0000_0018) begin errors++; $display("FAIL cont_busy: got %h want 00000018", busy_mask); end
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'd1;
        m_valid = 1'b1; m_rd = 5'd4; m_data = 32'd2;
        #1;
        checks++; if ({a_ready, m_ready} !== 2'b10) begin errors++; $display("FAIL cont_grant1: got %b want 10", {a_ready, m_ready}); end
        step();
        checks++; if ({rd_write_enb, rd_address, rd_data_in} !== {1'b1, 5'd3, 32'd1}) begin errors++; $display("FAIL cont_write1: got %0b/%0d/%0d want 1/3/1", rd_write_enb, rd_address, rd_data_in); end
        checks++; if ({a_ready, m_ready} !== 2'b01) begin errors++; $display("FAIL cont_grant2: got %b want 01", {a_ready, m_ready}); end
        step();
        a_valid = 1'b0; m_valid = 1'b0;
        checks++; if ({rd_write_enb, rd_address, rd_data_in} !== {1'b1, 5'd4, 32'd2}) begin errors++; $display("FAIL cont_write2: got %0b/%0d/%0d want 1/4/2", rd_write_enb, rd_address, rd_data_in); end
        a_valid = 1'b1; m_valid = 1'b1;
        #1;
        checks++; if ({a_ready, m_ready} !== 2'b10) begin errors++; $display("FAIL cont_grant3: got %b want 10", {a_ready, m_ready}); end
        a_valid = 1'b0; m_valid = 1'b0;
        step();
        checks++; if (rd_write_enb !== 1'b0) begin errors++; $display("FAIL cont_idle_wen: got %0b want 0", rd_write_enb); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL cont_busy_clear: got %h want 0", busy_mask); end
        checks++; if ({rf[3], rf[4]} !== {32'd1, 32'd2}) begin errors++; $display("FAIL cont_rf: got %0d/%0d want 1/2", rf[3], rf[4]); end
    endtask

    task automatic test_x0_write();
        m_valid = 1'b1; m_rd = 5'd0; m_data = 32'h0000_FFFF;
        #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0b want 1", m_ready); end
        step();
        m_valid = 1'b0;
        checks++; if (rd_write_enb !== 1'b0) begin errors++; $display("FAIL x0_wen: got %0b want 0", rd_write_enb); end
        checks++; if (rd_data_in !== 32'h0000_FFFF) begin errors++; $display("FAIL x0_data: got %h want 0000ffff", rd_data_in); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h want 0", busy_mask); end
        checks++; if (wb_unexpected !== 1'b0) begin errors++; $display("FAIL x0_unexp: got %0b want 0", wb_unexpected); end
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_first_ready: got %0b want 1", issue_ready); end
        step();
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_stall: got %0b want 0", issue_ready); end
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
        step();
        a_valid = 1'b0;
        checks++; if (rd_write_enb !== 1'b1) begin errors++; $display("FAIL waw_wen: got %0b want 1", rd_write_enb); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_bypass_ready: got %0b want 1", issue_ready); end
        step();
        issue_valid = 1'b0;
        checks++; if (busy_mask !== 32'h0000_0080) begin errors++; $display("FAIL waw_set_wins: got %h want 00000080", busy_mask); end
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h78;
        step();
        a_valid = 1'b0;
        step();
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL waw_drain: got %h want 0", busy_mask); end
        checks++; if (wb_unexpected !== 1'b0) begin errors++; $display("FAIL waw_unexp: got %0b want 0", wb_unexpected); end
    endtask

    task automatic test_unexpected();
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
        step();
        a_valid = 1'b0;
        checks++; if (wb_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_set: got %0b want 1", wb_unexpected); end
        checks++; if ({rd_write_enb, rd_address} !== {1'b1, 5'd9}) begin errors++; $display("FAIL unexp_write: got %0b/%0d want 1/9", rd_write_enb, rd_address); end
        step();
        checks++; if (rf[9] !== 32'h99) begin errors++; $display("FAIL unexp_rf: got %h want 99", rf[9]); end
        repeat (3) step();
        checks++; if (wb_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %0b want 1", wb_unexpected); end
    endtask

    task automatic test_reset_mid_write();
        issue_valid = 1'b1; issue_rd = 5'd10;
        step();
        issue_rd = 5'd11;
        a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hA;
        step();
        issue_valid = 1'b0; a_valid = 1'b0;
        checks++; if ({rd_write_enb, rd_address} !== {1'b1, 5'd10}) begin errors++; $display("FAIL rmid_write: got %0b/%0d want 1/10", rd_write_enb, rd_address); end
        checks++; if (busy_mask !== 32'h0000_0C00) begin errors++; $display("FAIL rmid_busy: got %h want 00000c00", busy_mask); end
        rst = 1'b1;
        #1;
        checks++; if (rd_write_enb !== 1'b0) begin errors++; $display("FAIL rmid_wen_drop: got %0b want 0", rd_write_enb); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL rmid_busy_clear: got %h want 0", busy_mask); end
        checks++; if (wb_unexpected !== 1'b0) begin errors++; $display("FAIL rmid_unexp_clear: got %0b want 0", wb_unexpected); end
        step();
        rst = 1'b0;
        checks++; if (rf[10] !== 32'h0) begin errors++; $display("FAIL rmid_rf_nowrite: got %h want 0", rf[10]); end
        a_valid = 1'b1; m_valid = 1'b1;
        #1;
        checks++; if ({a_ready, m_ready} !== 2'b10) begin errors++; $display("FAIL rmid_tie: got %b want 10", {a_ready, m_ready}); end
        a_valid = 1'b0; m_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        m_valid = 1'b0; m_rd = '0; m_data = '0;
        chk1_address = '0; chk2_address = '0;
        repeat (2) step();
        rst = 1'b0;
        test_reset();
        test_single_alu();
        test_contention();
        test_x0_write();
        test_waw();
        test_unexpected();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
